// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: PC select codes, mode encoding,
// Cause bit positions and ExcCode values (also used by the kernel register decode).
package exc_ctrl_pkg;

  localparam logic [31:0] EXC_VEC = 32'h8000_0004;
  localparam logic [31:0] RST_EPC = 32'h0000_0000;

  localparam logic [1:0] PC_NEXT = 2'd0;
  localparam logic [1:0] PC_VEC  = 2'd1;
  localparam logic [1:0] PC_EPC  = 2'd2;
  localparam logic [1:0] PC_HOLD = 2'd3;

  typedef enum logic [1:0] {
    StUser   = 2'd0,
    StKernel = 2'd1,
    StHalt   = 2'd2
  } exc_state_e;

  localparam int unsigned CauseErrInst = 0;
  localparam int unsigned CauseOvf     = 1;
  localparam int unsigned CauseTcOvf   = 2;
  localparam int unsigned CauseRxRdy   = 3;
  localparam int unsigned CauseTxRdy   = 4;
  localparam int unsigned CauseCodeLsb = 8;
  localparam int unsigned CauseCodeMsb = 10;
  localparam int unsigned CauseDouble  = 31;

  localparam logic [2:0] ExcNone    = 3'd0;
  localparam logic [2:0] ExcErrInst = 3'd1;
  localparam logic [2:0] ExcOvf     = 3'd2;
  localparam logic [2:0] ExcTcOvf   = 3'd3;
  localparam logic [2:0] ExcRxRdy   = 3'd4;
  localparam logic [2:0] ExcTxRdy   = 3'd5;

endpackage

// File: rtl/exc_prio.sv
// Fixed-priority encoder turning the taken event set into an ExcCode.
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic       err_i,
  input  logic       ovf_i,
  input  logic       tc_i,
  input  logic       rx_i,
  input  logic       tx_i,
  output logic [2:0] code_o
);

  always_comb begin
    code_o = ExcNone;
    if (err_i)      code_o = ExcErrInst;
    else if (ovf_i) code_o = ExcOvf;
    else if (tc_i)  code_o = ExcTcOvf;
    else if (rx_i)  code_o = ExcRxRdy;
    else if (tx_i)  code_o = ExcTxRdy;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: arbitrates sync exceptions and masked interrupts,
// owns EPC/Cause/Mask/Pend and the user/kernel/halt mode, and steers the PC.
module exc_ctrl
  import exc_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        err_inst_i,
  input  logic        ovf_i,
  input  logic        eret_i,
  input  logic [2:0]  int_src_i,
  input  logic        mask_wr_i,
  input  logic [2:0]  mask_in_i,
  input  logic [2:0]  ack_i,
  output logic [1:0]  pc_sel_o,
  output logic [31:0] epc_o,
  output logic [31:0] cause_o,
  output logic [2:0]  pend_o,
  output logic        kernel_o,
  output logic        wr_kill_o
);

  exc_state_e  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [2:0]  mask_q, mask_d;
  logic [2:0]  pend_q, pend_d;

  logic        is_user;
  logic        err_eff;
  logic [2:0]  ext;
  logic [2:0]  exc_code;
  logic [1:0]  pc_sel;
  logic        wr_kill;

  assign is_user = (state_q == StUser);
  // A user-mode eret is privileged and is reported as an illegal instruction.
  assign err_eff = err_inst_i | (eret_i & is_user);
  assign ext     = (pend_q | int_src_i) & mask_q;

  exc_prio u_prio (
    .err_i  (err_eff),
    .ovf_i  (ovf_i),
    .tc_i   (ext[0]),
    .rx_i   (ext[1]),
    .tx_i   (ext[2]),
    .code_o (exc_code)
  );

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    pc_sel  = PC_NEXT;
    wr_kill = 1'b0;
    unique case (state_q)
      StUser: begin
        pend_d = pend_q | int_src_i;
        if (err_eff || ovf_i || (ext != 3'b000)) begin
          pc_sel  = PC_VEC;
          wr_kill = 1'b1;
          epc_d   = pc_i;
          cause_d = '0;
          cause_d[CauseCodeMsb:CauseCodeLsb] = exc_code;
          cause_d[CauseTxRdy:CauseTcOvf]     = ext;
          cause_d[CauseOvf]                  = ovf_i;
          cause_d[CauseErrInst]              = err_eff;
          state_d = StKernel;
        end
      end
      StKernel: begin
        if (err_inst_i || ovf_i) begin
          // Double fault: the faulting kernel instruction must not touch Mask or Ack.
          pc_sel  = PC_HOLD;
          wr_kill = 1'b1;
          pend_d  = pend_q | int_src_i;
          cause_d[CauseDouble]  = 1'b1;
          cause_d[CauseOvf]     = cause_q[CauseOvf] | ovf_i;
          cause_d[CauseErrInst] = cause_q[CauseErrInst] | err_inst_i;
          state_d = StHalt;
        end else begin
          pend_d = (pend_q & ~ack_i) | int_src_i;
          if (mask_wr_i) mask_d = mask_in_i;
          if (eret_i) begin
            pc_sel  = PC_EPC;
            state_d = StUser;
          end
        end
      end
      default: begin
        pc_sel  = PC_HOLD;
        wr_kill = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StKernel;
      epc_q   <= RST_EPC;
      cause_q <= '0;
      mask_q  <= 3'b000;
      pend_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
    end
  end

  assign pc_sel_o  = rst_ni ? pc_sel : PC_NEXT;
  assign wr_kill_o = rst_ni & wr_kill;
  assign epc_o     = epc_q;
  assign cause_o   = cause_q;
  assign pend_o    = pend_q;
  assign kernel_o  = (state_q != StUser);

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model of the controller.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        err = 1'b0, ovf = 1'b0, eret = 1'b0, mw = 1'b0;
  logic [2:0]  src = '0, mi = '0, ack = '0;

  logic [1:0]  pc_sel_w;
  logic [31:0] epc_w, cause_w;
  logic [2:0]  pend_w;
  logic        kernel_w, kill_w;

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pc_i       (pc),
    .err_inst_i (err),
    .ovf_i      (ovf),
    .eret_i     (eret),
    .int_src_i  (src),
    .mask_wr_i  (mw),
    .mask_in_i  (mi),
    .ack_i      (ack),
    .pc_sel_o   (pc_sel_w),
    .epc_o      (epc_w),
    .cause_o    (cause_w),
    .pend_o     (pend_w),
    .kernel_o   (kernel_w),
    .wr_kill_o  (kill_w)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = user, 1 = kernel, 2 = halt.
  localparam int MUser = 0, MKernel = 1, MHalt = 2;
  int          m_mode = MKernel, x_mode = MKernel;
  logic [31:0] m_epc = '0, m_cause = '0, x_epc = '0, x_cause = '0;
  logic [2:0]  m_mask = '0, m_pend = '0, x_mask = '0, x_pend = '0;

  always @(negedge clk) begin
    logic [2:0] ext;
    logic [4:0] taken;
    logic       err_e;
    int         sel, code;
    bit         kill;
    if (!rst_n) begin
      chk("rst_pc_sel", pc_sel_w, 0);
      chk("rst_wr_kill", kill_w, 0);
      chk("rst_epc", epc_w, 0);
      chk("rst_cause", cause_w, 0);
      chk("rst_pend", pend_w, 0);
      chk("rst_kernel", kernel_w, 1);
    end else begin
      chk("m_epc", epc_w, m_epc);
      chk("m_cause", cause_w, m_cause);
      chk("m_pend", pend_w, m_pend);
      chk("m_kernel", kernel_w, m_mode != MUser);
      x_mode = m_mode; x_epc = m_epc; x_cause = m_cause; x_mask = m_mask; x_pend = m_pend;
      sel = 0; kill = 0;
      err_e = err | (eret && m_mode == MUser);
      ext = (m_pend | src) & m_mask;
      if (m_mode == MUser) begin
        x_pend = m_pend | src;
        taken = {ext, ovf, err_e};
        if (taken != 0) begin
          code = 0;
          for (int i = 4; i >= 0; i--) if (taken[i]) code = i + 1;
          sel = 1; kill = 1;
          x_epc = pc;
          x_cause = (32'(code) << 8) | {27'b0, taken};
          x_mode = MKernel;
        end
      end else if (m_mode == MKernel) begin
        if (err || ovf) begin
          sel = 3; kill = 1;
          x_cause = m_cause | 32'h8000_0000 | {30'b0, ovf, err};
          x_pend = m_pend | src;
          x_mode = MHalt;
        end else begin
          x_pend = (m_pend & ~ack) | src;
          if (mw) x_mask = mi;
          if (eret) begin
            sel = 2;
            x_mode = MUser;
          end
        end
      end else begin
        sel = 3; kill = 1;
      end
      chk("m_pc_sel", pc_sel_w, sel);
      chk("m_wr_kill", kill_w, kill);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= MKernel; m_epc <= '0; m_cause <= '0; m_mask <= '0; m_pend <= '0;
    end else begin
      m_mode <= x_mode; m_epc <= x_epc; m_cause <= x_cause; m_mask <= x_mask; m_pend <= x_pend;
    end
  end

  task automatic clr();
    err = 0; ovf = 0; eret = 0; src = 0; mw = 0; mi = 0; ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;

    // Boot eret into user mode at RST_EPC.
    pc = 32'h8000_0010; eret = 1;
    @(negedge clk);
    chk("boot_eret_sel", pc_sel_w, 2);
    chk("boot_eret_kill", kill_w, 0);
    chk("boot_eret_epc", epc_w, 32'h0);
    tick(); clr();
    chk("boot_user", kernel_w, 0);

    // Illegal instruction in user mode.
    pc = 32'h40; err = 1;
    @(negedge clk);
    chk("err_sel", pc_sel_w, 1);
    chk("err_kill", kill_w, 1);
    tick(); clr();
    chk("err_epc", epc_w, 32'h40);
    chk("err_cause", cause_w, 32'h101);
    chk("err_kernel", kernel_w, 1);

    // Masked TCOvf pulse stays pending, then unmask on the eret cycle.
    mw = 1; mi = 3'b010; tick(); clr();
    src = 3'b001; tick(); clr();
    chk("pulse_pend", pend_w, 3'b001);
    pc = 32'h8000_0020; eret = 1; tick(); clr();
    pc = 32'h44;
    @(negedge clk);
    chk("masked_no_take", pc_sel_w, 0);
    tick();
    pc = 32'h48; err = 1; tick(); clr();
    mw = 1; mi = 3'b011; eret = 1; tick(); clr();
    pc = 32'h50;
    @(negedge clk);
    chk("unmask_take", pc_sel_w, 1);
    tick(); clr();
    chk("unmask_cause", cause_w, 32'h304);
    chk("unmask_epc", epc_w, 32'h50);

    // Set wins over ack; ack alone clears.
    ack = 3'b001; src = 3'b001; tick(); clr();
    chk("set_wins", pend_w, 3'b001);
    ack = 3'b001; tick(); clr();
    chk("ack_clears", pend_w, 3'b000);

    // Overflow and RxRdy together: one take.
    eret = 1; tick(); clr();
    pc = 32'h100; ovf = 1; src = 3'b010;
    @(negedge clk);
    chk("dual_sel", pc_sel_w, 1);
    tick(); clr();
    chk("dual_cause", cause_w, 32'h20A);
    chk("dual_epc", epc_w, 32'h100);
    ack = 3'b010; tick(); clr();

    // Kernel overflow: double fault into halt.
    ovf = 1;
    @(negedge clk);
    chk("dfault_sel", pc_sel_w, 3);
    chk("dfault_kill", kill_w, 1);
    tick(); clr();
    chk("dfault_cause", cause_w, 32'h8000_020A);
    chk("dfault_kernel", kernel_w, 1);
    for (int i = 0; i < 4; i++) begin
      err = 1'($urandom); eret = 1'($urandom); src = 3'($urandom); tick();
    end
    @(negedge clk);
    chk("halt_sel", pc_sel_w, 3);
    chk("halt_cause", cause_w, 32'h8000_020A);
    chk("halt_pend", pend_w, 0);
    chk("halt_epc", epc_w, 32'h100);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_sel", pc_sel_w, 0);
    chk("async_cause", cause_w, 0);
    chk("async_epc", epc_w, 0);
    chk("async_kernel", kernel_w, 1);
    tick(); clr();
    rst_n = 1;

    // Randomised run against the model; reset occasionally and to leave halt.
    for (int c = 0; c < 4000; c++) begin
      rst_n = !(m_mode == MHalt && $urandom_range(0, 3) == 0) && ($urandom_range(0, 299) != 0);
      pc   = $urandom;
      err  = ($urandom_range(0, 29) == 0);
      ovf  = ($urandom_range(0, 29) == 0);
      eret = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 3; b++) src[b] = ($urandom_range(0, 5) == 0);
      mw   = ($urandom_range(0, 5) == 0);
      mi   = 3'($urandom);
      ack  = 3'($urandom);
      tick();
    end
    rst_n = 1; clr();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
